// File: rtl/cam_frame_capture.sv
// Camera capture path: samples an OV7670-style bus in the system clock domain, assembles pixels,
// applies format conversion and decimation, and emits linear-address RAM write strobes.
module cam_frame_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DECIM_LOG2 = 0,
  parameter int ADDR_W     = 19,
  parameter int OUT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic [1:0]        mode,
  input  logic              continuous,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              line_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  output logic [1:0]        fsm_state
);

  localparam int XW    = $clog2(H_ACTIVE + 1) + 1;
  localparam int YW    = $clog2(V_ACTIVE + 1) + 1;
  localparam int TOTAL = (H_ACTIVE >> DECIM_LOG2) * (V_ACTIVE >> DECIM_LOG2);
  localparam int DMASK = (1 << DECIM_LOG2) - 1;

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t            state;
  logic              pclk_s1, pclk_s2, pclk_prev;
  logic              vsync_s1, vsync_s2, vs_d, vs_d2;
  logic              href_s1, href_s2, href_d, href_d2;
  logic [7:0]        data_s1, data_s2, data_d;
  logic              pix_ev;
  logic              phase;
  logic [7:0]        hi;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              full;
  logic [1:0]        mode_q;

  // pix_ev, href_d, vs_d and data_d are all one stage behind the synchronisers, so they line up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_s1 <= 1'b0; pclk_s2 <= 1'b0; pclk_prev <= 1'b0;
      vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vs_d <= 1'b0; vs_d2 <= 1'b0;
      href_s1 <= 1'b0; href_s2 <= 1'b0; href_d <= 1'b0; href_d2 <= 1'b0;
      data_s1 <= 8'h00; data_s2 <= 8'h00; data_d <= 8'h00;
      pix_ev <= 1'b0;
    end else begin
      pclk_s1 <= cam_pclk;   pclk_s2 <= pclk_s1;   pclk_prev <= pclk_s2;
      vsync_s1 <= cam_vsync; vsync_s2 <= vsync_s1; vs_d <= vsync_s2; vs_d2 <= vs_d;
      href_s1 <= cam_href;   href_s2 <= href_s1;   href_d <= href_s2; href_d2 <= href_d;
      data_s1 <= cam_data;   data_s2 <= data_s1;   data_d <= data_s2;
      pix_ev <= pclk_s2 & ~pclk_prev;
    end
  end

  logic vs_fall, vs_rise, href_fall, keep;
  assign vs_fall   = vs_d2 & ~vs_d;
  assign vs_rise   = ~vs_d2 & vs_d;
  assign href_fall = href_d2 & ~href_d;
  assign keep      = (x < XW'(H_ACTIVE)) && ((x & XW'(DMASK)) == '0) &&
                     ((y & YW'(DMASK)) == '0) && !full;

  function automatic logic [OUT_W-1:0] fmt(input logic [1:0] m, input logic [7:0] h,
                                           input logic [7:0] l);
    case (m)
      2'd0:    fmt = OUT_W'(h[7:4]);
      2'd2:    fmt = OUT_W'({h[7:5], h[2:0], l[4:3]});
      default: fmt = OUT_W'({h, l});
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      phase      <= 1'b0;
      hi         <= 8'h00;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      full       <= 1'b0;
      mode_q     <= 2'd0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start || continuous) begin
            state  <= WAIT_VS;
            busy   <= 1'b1;
            mode_q <= mode;
            if (start) line_err <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_VS: begin
          if (vs_fall) begin
            state <= CAPTURE;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            full  <= 1'b0;
            phase <= 1'b0;
          end
        end
        CAPTURE: begin
          if (vs_rise || y == YW'(V_ACTIVE)) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else if (href_fall) begin
            phase <= 1'b0;
            x     <= '0;
            if (y != '1) y <= y + 1'b1;
            if (x != XW'(H_ACTIVE)) line_err <= 1'b1;
          end else if (pix_ev && href_d) begin
            if (!phase) begin
              hi    <= data_d;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (x != '1) x <= x + 1'b1;
              if (keep) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= fmt(mode_q, hi, data_d);
                // The last address sets full instead of wrapping to 0.
                if (addr == ADDR_W'(TOTAL - 1)) full <= 1'b1;
                else addr <= addr + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture: two instances (4x2 no decimation, 8x4 with D=1) share the camera bus;
// expected writes are queued by the stimulus and popped by a monitor on every wr_en.
module tb_cam_frame_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cam_pclk, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic [1:0]  mode;
  logic        continuous0, continuous1, start0, start1;
  logic        busy0, frame_done0, line_err0, wr_en0;
  logic        busy1, frame_done1, line_err1, wr_en1;
  logic [3:0]  wr_addr0, wr_addr1;
  logic [15:0] wr_data0, wr_data1;
  logic [1:0]  fsm_state0, fsm_state1;

  cam_frame_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM_LOG2(0), .ADDR_W(4), .OUT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .mode(mode), .continuous(continuous0), .start(start0),
    .busy(busy0), .frame_done(frame_done0), .line_err(line_err0), .wr_en(wr_en0),
    .wr_addr(wr_addr0), .wr_data(wr_data0), .fsm_state(fsm_state0)
  );

  cam_frame_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM_LOG2(1), .ADDR_W(4), .OUT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .mode(mode), .continuous(continuous1), .start(start1),
    .busy(busy1), .frame_done(frame_done1), .line_err(line_err1), .wr_en(wr_en1),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .fsm_state(fsm_state1)
  );

  int checks = 0;
  int errors = 0;
  int fd0 = 0, fd1 = 0;
  int fd0_exp = 0;
  logic [19:0] exp0_q[$];
  logic [19:0] exp1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of that instance's expected queue.
  always @(negedge clk) begin
    if (frame_done0) fd0++;
    if (frame_done1) fd1++;
    if (wr_en0) begin
      if (exp0_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_write: got addr %0h data %0h, expected no write",
                 wr_addr0, wr_data0);
      end else begin
        check("dut0_write", {12'h0, wr_addr0, wr_data0}, {12'h0, exp0_q[0]});
        void'(exp0_q.pop_front());
      end
    end
    if (wr_en1) begin
      if (exp1_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_write: got addr %0h data %0h, expected no write",
                 wr_addr1, wr_data1);
      end else begin
        check("dut1_write", {12'h0, wr_addr1, wr_data1}, {12'h0, exp1_q[0]});
        void'(exp1_q.pop_front());
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    wait_clk(4);
    cam_pclk = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_line(input int n, input logic [7:0] hi0, input logic [7:0] lo0,
                           input logic [7:0] step);
    logic [7:0] h, l;
    cam_pclk = 1'b0;
    cam_href = 1'b1;
    for (int k = 0; k < n; k++) begin
      h = hi0 + 8'(k) * step;
      l = lo0 + 8'(k) * step;
      cam_byte(h);
      cam_byte(l);
    end
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    wait_clk(16);
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    wait_clk(1);
    start0 = 1'b0;
  endtask

  task automatic push0(input logic [3:0] a, input logic [15:0] d);
    exp0_q.push_back({a, d});
  endtask

  task automatic push1(input logic [3:0] a, input logic [15:0] d);
    exp1_q.push_back({a, d});
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp0_q.size() + exp1_q.size()) != 0 && t < 400) begin
      wait_clk(1);
      t++;
    end
    check(name, exp0_q.size() + exp1_q.size(), 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] h;
    logic [3:0] a;
    reset = 1'b0;
    cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    mode = 2'd1; continuous0 = 1'b0; continuous1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    wait_clk(5);
    check("reset_outputs0", {busy0, frame_done0, line_err0, wr_en0, wr_addr0, wr_data0}, 0);
    check("reset_outputs1", {busy1, frame_done1, line_err1, wr_en1, wr_addr1, wr_data1}, 0);
    check("reset_state0", fsm_state0, 0);
    reset = 1'b1;
    wait_clk(5);

    // 4x2 RGB565 frame, single shot
    mode = 2'd1;
    pulse_start0();
    check("busy_after_start", busy0, 1);
    for (int n = 0; n < 8; n++) push0(4'(n), {8'(8'hA0 + n), 8'(8'h50 + n)});
    frame_begin();
    send_line(4, 8'hA0, 8'h50, 8'h01);
    send_line(4, 8'hA4, 8'h54, 8'h01);
    frame_end();
    fd0_exp++;
    drain("t1_drain");
    check("t1_frame_done", fd0, fd0_exp);
    check("t1_busy_idle", busy0, 0);

    // Formats: RGB332, grey4 (mode changed mid-frame must not matter), reserved mode as RGB565
    mode = 2'd2;
    pulse_start0();
    for (int n = 0; n < 8; n++) push0(4'(n), 16'h00E3);
    frame_begin();
    send_line(4, 8'hF8, 8'h1F, 8'h00);
    send_line(4, 8'hF8, 8'h1F, 8'h00);
    frame_end();
    mode = 2'd0;
    pulse_start0();
    for (int n = 0; n < 8; n++) push0(4'(n), 16'h0009);
    frame_begin();
    mode = 2'd1;
    send_line(4, 8'h9C, 8'h55, 8'h00);
    send_line(4, 8'h9C, 8'h55, 8'h00);
    frame_end();
    mode = 2'd3;
    pulse_start0();
    for (int n = 0; n < 8; n++) push0(4'(n), 16'h1234);
    frame_begin();
    send_line(4, 8'h12, 8'h34, 8'h00);
    send_line(4, 8'h12, 8'h34, 8'h00);
    frame_end();
    fd0_exp += 3;
    drain("t2_drain");
    check("t2_frame_done", fd0, fd0_exp);

    // D=1 decimation on the 8x4 instance
    mode = 2'd1;
    start1 = 1'b1;
    wait_clk(1);
    start1 = 1'b0;
    a = 4'd0;
    for (int yy = 0; yy < 4; yy += 2)
      for (int xx = 0; xx < 8; xx += 2) begin
        h = 8'(16 * yy + xx);
        push1(a, {h, 8'(8'h30 + xx)});
        a = a + 4'd1;
      end
    frame_begin();
    for (int yy = 0; yy < 4; yy++) send_line(8, 8'(16 * yy), 8'h30, 8'h01);
    frame_end();
    drain("t3_drain");
    check("t3_line_err", line_err1, 0);
    check("t3_frame_done", fd1, 1);
    check("t3_busy_idle", busy1, 0);

    // Short line then long line: sticky line_err, overflow pixel dropped
    pulse_start0();
    for (int k = 0; k < 3; k++) push0(4'(k), {8'(8'h40 + k), 8'(8'h60 + k)});
    for (int k = 0; k < 4; k++) push0(4'(3 + k), {8'(8'h48 + k), 8'(8'h68 + k)});
    frame_begin();
    send_line(3, 8'h40, 8'h60, 8'h01);
    check("t4_line_err_short", line_err0, 1);
    send_line(5, 8'h48, 8'h68, 8'h01);
    frame_end();
    fd0_exp++;
    drain("t4_drain");
    check("t4_line_err_sticky", line_err0, 1);
    check("t4_frame_done", fd0, fd0_exp);
    pulse_start0();
    wait_clk(2);
    check("t4_line_err_cleared", line_err0, 0);

    // Continuous: three frames, address restarts, start mid-frame ignored
    continuous0 = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 8; n++) push0(4'(n), {8'(8'hC0 + 16 * f + n), 8'(n)});
      frame_begin();
      if (f == 2) continuous0 = 1'b0;
      send_line(4, 8'(8'hC0 + 16 * f), 8'h00, 8'h01);
      if (f == 1) pulse_start0();
      send_line(4, 8'(8'hC4 + 16 * f), 8'h04, 8'h01);
      frame_end();
    end
    fd0_exp += 3;
    drain("t5_drain");
    check("t5_frame_done", fd0, fd0_exp);
    check("t5_busy_idle", busy0, 0);

    // Reset mid-capture
    pulse_start0();
    for (int k = 0; k < 3; k++) push0(4'(k), {8'(8'h20 + k), 8'(8'h70 + k)});
    push0(4'd3, 16'h2373);
    frame_begin();
    send_line(3, 8'h20, 8'h70, 8'h01);
    check("t6_line_err_before", line_err0, 1);
    cam_href = 1'b1;
    cam_byte(8'h23);
    cam_byte(8'h73);
    wait_clk(6);
    drain("t6_drain");
    cam_byte(8'h24);
    reset = 1'b0;
    #1;
    check("t6_reset_outputs", {busy0, frame_done0, line_err0, wr_en0, wr_addr0, wr_data0}, 0);
    check("t6_reset_state", fsm_state0, 0);
    wait_clk(5);
    reset = 1'b1;
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    wait_clk(4);
    frame_end();
    frame_begin();
    send_line(4, 8'h11, 8'h22, 8'h01);
    send_line(4, 8'h15, 8'h26, 8'h01);
    frame_end();
    check("t6_no_frame_done", fd0, fd0_exp);
    check("t6_idle_busy", busy0, 0);
    check("t6_idle_state", fsm_state0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
